// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, single-outstanding imem requests, redirect/kill handling.
// Optional FETCH_BUF_EN adds a 2-entry instruction buffer so fetch can run ahead during stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         PCSel,
  input  logic [31:0]        alu_target,
  input  logic [31:0]        pred_target,
  input  logic [31:0]        correct_target,
  input  logic               stall,
  input  logic               killF,
  fetch_unit_if.master       imem,
  output logic [31:0]        instF,
  output logic [31:0]        pcF,
  output logic [31:0]        pc4F,
  output logic               validF
);
  typedef enum logic [1:0] {RST, WAIT, DROP} state_t;

  state_t      state;
  logic [31:0] pc_req;
  logic [31:0] drop_addr;
  logic        redirect;
  logic [31:0] target;
  logic        req;
  logic        take;
  logic        adv;
  logic [31:0] adv_inst;
  logic [31:0] adv_pc;

  always_comb begin
    redirect = 1'b1;
    target   = 32'h0;
    case (PCSel)
      3'd1:    target = alu_target;
      3'd2:    target = pred_target;
      3'd3:    target = correct_target;
      default: redirect = 1'b0;
    endcase
    target[1:0] = 2'b00;
  end

`ifdef FETCH_BUF_EN
  logic [31:0] buf_inst [2];
  logic [31:0] buf_pc   [2];
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic        push;
  logic        pop;

  assign req      = (state == DROP) || ((state == WAIT) && (count != 2'd2));
  assign take     = (state == WAIT) && (count != 2'd2) && imem.imem_rvalid && !redirect;
  assign adv      = (state != RST) && !redirect && !killF && !stall && ((count != 2'd0) || take);
  assign adv_inst = (count != 2'd0) ? buf_inst[rd_ptr] : imem.imem_rdata;
  assign adv_pc   = (count != 2'd0) ? buf_pc[rd_ptr] : pc_req;
  // An empty buffer lets a response go straight to F instead of being queued.
  assign push     = take && !(adv && (count == 2'd0));
  assign pop      = adv && (count != 2'd0);

  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wr_ptr] <= imem.imem_rdata;
      buf_pc[wr_ptr]   <= pc_req;
    end
    if (!rst_n || redirect) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      count  <= count + {1'b0, push} - {1'b0, pop};
      rd_ptr <= rd_ptr ^ pop;
      wr_ptr <= wr_ptr ^ push;
    end
  end
`else
  // Stalled or killed responses are left unconsumed; memory re-presents them.
  assign req      = (state != RST);
  assign take     = (state == WAIT) && imem.imem_rvalid && !redirect && !killF && !stall;
  assign adv      = take;
  assign adv_inst = imem.imem_rdata;
  assign adv_pc   = pc_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RST;
      pc_req    <= RESET_PC;
      drop_addr <= RESET_PC;
      instF     <= NOP_INST;
      pcF       <= RESET_PC;
      validF    <= 1'b0;
    end else if (state == RST) begin
      state <= WAIT;
    end else begin
      if (redirect)
        pc_req <= target;
      else if (take)
        pc_req <= pc_req + 32'd4;

      // The stale request keeps its own address until its response is swallowed.
      if (redirect && (state == WAIT) && req && !imem.imem_rvalid) begin
        state     <= DROP;
        drop_addr <= pc_req;
      end else if ((state == DROP) && imem.imem_rvalid) begin
        state <= WAIT;
      end

      if (redirect || killF) begin
        instF  <= NOP_INST;
        validF <= 1'b0;
      end else if (adv) begin
        instF  <= adv_inst;
        pcF    <= adv_pc;
        validF <= 1'b1;
      end
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = (state == DROP) ? drop_addr : pc_req;
  assign pc4F           = pcF + 32'd4;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end for the 5-stage RISC-V pipeline. It owns the fetch PC, issues single-outstanding requests to instruction memory, and presents `instF`/`pcF` to the pipeline control and datapath. It is driven by the pipeline control unit's `PCSel`, stall and killF outputs, and is the consumer of the redirect decisions that unit makes. Redirects and kills flush in-flight fetches and replace the F-stage instruction with a NOP.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INST`, 32'h0000_0013, instruction injected on kill/flush (`addi x0,x0,0`)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `PCSel`  in  3  next-PC select: 0 = sequential, 1 = `alu_target` (resolved in X), 2 = `pred_target` (static predict in F), 3 = `correct_target` (mispredict recovery); 4–7 treated as 0
- `alu_target`, `pred_target`, `correct_target`  in  32 each  redirect addresses (bit 1:0 ignored, forced 0)
- `stall`  in  1  hold F stage (instF/pcF unchanged)
- `killF`  in  1  squash current F instruction
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  fetch address, stable while `imem_req` and no response
- `imem_rvalid`  in  1  response valid (same cycle as request allowed)
- `imem_rdata`  in  32  fetched word
- `instF`  out  32  F-stage instruction
- `pcF`, `pc4F`  out  32 each  F-stage PC and PC+4
- `validF`  out  1  `instF` holds a real fetched instruction

## Operation
- State machine: `RST` → `WAIT` → (`WAIT` | `DROP`).
  - `RST`: entered whenever `rst_n`=0.
  - `WAIT`: `imem_req`=1, `imem_addr`=`pc_req`.
  - `DROP`: a redirect arrived while a request was outstanding. The response is awaited and discarded, then the FSM goes to `WAIT` at the redirected address.
- Advance (no stall, `imem_rvalid`=1 in `WAIT`):
  - `instF`←`imem_rdata`, `pcF`←`pc_req`, `validF`←1.
  - `pc_req`←next PC.
- Next PC: `pc_req`+4 when `PCSel`=0; otherwise the selected target.
- Redirect (`PCSel`≠0), evaluated every cycle regardless of stall:
  - `pc_req`←target.
  - `instF`←`NOP_INST`, `validF`←0.
  - An outstanding un-responded request moves the FSM to `DROP`; if `imem_rvalid` is high in the same cycle, the data is discarded and the FSM stays in `WAIT` at the new address.
- `killF`=1: next edge `instF`←`NOP_INST`, `validF`←0. `pc_req` is unaffected unless `PCSel`≠0.
- Priority: reset > redirect > killF > stall > advance.
- Stall with response: without buffering (see Configuration), `imem_rvalid` during stall is not consumed. `imem_req` stays high with the same address until stall drops; the memory re-presents the data.
- Address arithmetic: 32-bit, wraps modulo 2^32 (0xFFFF_FFFC+4 = 0).

## Timing
- Reset values (cycle after `rst_n` sampled low):
  - `imem_req`=0, `imem_addr`=`RESET_PC`
  - `instF`=`NOP_INST`, `pcF`=`RESET_PC`, `pc4F`=`RESET_PC`+4, `validF`=0
- First `imem_req`=1 in the first cycle after `rst_n` is sampled high.
- Zero-wait memory (`rvalid` same cycle as `req`): one instruction per cycle. `instF` is updated at the edge ending the response cycle.
- N-wait memory: `instF` is updated at the edge ending the cycle `imem_rvalid`=1.
- Redirect penalty: the redirect target is requested the cycle after `PCSel`≠0 is sampled, or after the `DROP` response completes.
- Reset mid-request: the outstanding response is ignored. The fetch restarts at `RESET_PC`.
- `pc4F` is combinational from `pcF`; all other outputs are registered or derived from FSM state.

## Configuration
- `FETCH_BUF_EN` defined:
  - Adds a 2-entry FIFO between `imem_rdata` and `instF`.
  - Fetch continues during stall until the FIFO is full; `imem_req`=0 while full.
  - F advance pops from the FIFO when it is non-empty.
  - Redirect or reset empties the FIFO in the same edge.
  - Full and empty status are tracked with a 2-bit count.
- Undefined: no FIFO, and behaviour is exactly as in Operation.

## Test plan
- Reset release, zero-wait memory returning `addr` as data:
  - `imem_addr` = 0x0, 0x4, 0x8 on consecutive cycles.
  - `instF` = 0x0, 0x4, 0x8 one cycle behind, `validF`=1.
- 3-cycle memory latency with `PCSel`=1, `alu_target`=0x100 asserted during the wait:
  - The late response is discarded.
  - Next `imem_addr`=0x100; `instF`=0x13 until 0x100 returns.
- Stall held 4 cycles with response pending:
  - `instF`/`pcF` unchanged.
  - Without `FETCH_BUF_EN`: `imem_addr` held.
  - With `FETCH_BUF_EN`: two extra fetches (0x8, 0xC), then `imem_req`=0.
- `killF`=1 for one cycle with `PCSel`=0:
  - `instF`=0x13, `validF`=0 for that slot.
  - Sequential fetch continues with no address skipped.
- `pc_req`=0xFFFF_FFFC, `PCSel`=0: next `imem_addr`=0x0.
- `rst_n` low while a request is outstanding and `imem_rvalid` arrives in the reset cycle:
  - All outputs take their reset values.
  - First post-reset `imem_addr`=`RESET_PC`.
